// File: rtl/fsm_run_generator.sv
// -----------------------------------------------------------------------------
// fsm_run_generator
//
// Serial run-length pattern transmitter. It accepts "emit bit B for N
// consecutive cycles" commands over a valid/ready handshake and drives them
// out one bit per clock. Back-to-back commands are chained with no idle gap.
// Its `out` is intended to feed the `in` of a run detector.
//
// Optional feature macro: FSM_RUNGEN_PREDICT_EN
//   defined   : `match` flags every cycle in which four identical valid bits
//               have just been driven. The flag is aligned with `out`, so a
//               4-in-a-row detector on `out` asserts one cycle later.
//   undefined : the history logic is absent and `match` is tied to 0.
//
// Parameters
//   LEN_W      width of cmd_len; run lengths 0 .. 2^LEN_W-1
//
// Ports
//   clk        single clock, rising-edge
//   reset      synchronous, active-low
//   cmd_valid  command present
//   cmd_ready  a command can be accepted this cycle (combinational)
//   cmd_bit    bit value to emit
//   cmd_len    number of cycles to emit cmd_bit (0 = consume, emit nothing)
//   out        serial bit, 0 whenever out_valid is 0
//   out_valid  out carries a command bit this cycle
//   busy       run in progress (same as out_valid)
//   match      four-in-a-row predictor flag
//
// State table
//   state | meaning
//   IDLE  | no run active; ready for a command
//   RUN   | emitting cur_bit; remain = bits still to emit after this one
// -----------------------------------------------------------------------------
module fsm_run_generator #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             match
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic             cur_bit;
    logic [LEN_W-1:0] remain;

    logic             run_last;
    logic             accept;
    logic             load;

    // The last bit of a run is the only RUN cycle in which a new command can
    // be taken; taking it there is what removes the gap between commands.
    assign run_last  = (state == S_RUN) && (remain == '0);
    assign cmd_ready = reset & ((state == S_IDLE) | run_last);
    assign accept    = cmd_valid & cmd_ready;

    // Zero-length commands are consumed by the handshake but start nothing.
    assign load      = accept & (cmd_len != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cur_bit <= 1'b0;
            remain  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        state   <= S_RUN;
                        cur_bit <= cmd_bit;
                        remain  <= cmd_len - LEN_W'(1);
                    end
                end
                S_RUN: begin
                    if (remain != '0) begin
                        remain <= remain - LEN_W'(1);
                    end else if (load) begin
                        cur_bit <= cmd_bit;
                        remain  <= cmd_len - LEN_W'(1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == S_RUN);
    assign busy      = out_valid;
    assign out       = cur_bit & out_valid;

`ifdef FSM_RUNGEN_PREDICT_EN
    // hist[0] is the bit driven one cycle ago, hist[2] three cycles ago.
    // vcnt counts preceding consecutive valid cycles, saturating at 3, so
    // history entries are only trusted once three of them are real.
    logic [2:0] hist;
    logic [1:0] vcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist <= 3'b000;
            vcnt <= 2'd0;
        end else if (out_valid) begin
            hist <= {hist[1:0], cur_bit};
            if (vcnt != 2'd3) begin
                vcnt <= vcnt + 2'd1;
            end
        end else begin
            hist <= 3'b000;
            vcnt <= 2'd0;
        end
    end

    assign match = out_valid & (vcnt == 2'd3) & (hist == {3{cur_bit}});
`else
    assign match = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_run_generator.sv
module tb_fsm_run_generator;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_bit;
    logic [3:0] cmd_len;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       match;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue holds every bit still to appear on `out`,
    // element 0 being the bit of the current cycle. Previous three cycles are
    // kept as (valid, bit) pairs for the predictor.
    logic q[$];
    logic hv[3];
    logic hb[3];

    int   cnt_valid;
    int   cnt_match;

    fsm_run_generator #(.LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_bit   (cmd_bit),
        .cmd_len   (cmd_len),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .match     (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            hv[i] = 1'b0;
            hb[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, take
    // the edge, advance the model. Called right after a falling edge.
    task automatic cyc(input logic r, input logic v, input logic b,
                       input logic [3:0] l, output logic acc);
        logic e_ov, e_out, e_rdy, e_match;
        reset = r; cmd_valid = v; cmd_bit = b; cmd_len = l;
        #1;
        e_ov  = (q.size() > 0);
        e_out = e_ov ? q[0] : 1'b0;
        e_rdy = r && (q.size() <= 1);
`ifdef FSM_RUNGEN_PREDICT_EN
        e_match = e_ov && hv[0] && hv[1] && hv[2] &&
                  (hb[0] == e_out) && (hb[1] == e_out) && (hb[2] == e_out);
`else
        e_match = 1'b0;
`endif
        chk("out_valid", out_valid, e_ov);
        chk("busy", busy, e_ov);
        chk("out", out, e_out);
        chk("cmd_ready", cmd_ready, e_rdy);
        chk("match", match, e_match);
        if (out_valid === 1'b1) cnt_valid++;
        if (match === 1'b1) cnt_match++;
        acc = v && e_rdy;
        @(posedge clk);
        if (!r) begin
            model_clear();
        end else begin
            hv[2] = hv[1]; hb[2] = hb[1];
            hv[1] = hv[0]; hb[1] = hb[0];
            hv[0] = e_ov;  hb[0] = e_out;
            if (e_ov) void'(q.pop_front());
            if (acc) for (int i = 0; i < int'(l); i++) q.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), acc);
    endtask

    // Offer a command until accepted, bounded.
    task automatic send(input logic b, input logic [3:0] l);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) cyc(1'b1, 1'b1, b, l, acc);
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted");
        end
    endtask

    initial begin
        logic acc;
        int exp_m;
        reset = 1'b0; cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 4'd5;
        model_clear();
        cnt_valid = 0;
        cnt_match = 0;
        @(posedge clk);
        @(negedge clk);

        // Reset held with a command offered: nothing accepted.
        cyc(1'b0, 1'b1, 1'b1, 4'd5, acc);
        cyc(1'b0, 1'b1, 1'b1, 4'd5, acc);
        idle(1);

        // Single run (1,5).
        cnt_valid = 0; cnt_match = 0;
        send(1'b1, 4'd5);
        idle(7);
        chk_int("single_len", cnt_valid, 5);
`ifdef FSM_RUNGEN_PREDICT_EN
        exp_m = 2;
`else
        exp_m = 0;
`endif
        chk_int("single_match", cnt_match, exp_m);

        // Back-to-back (0,4) then (1,3).
        cnt_valid = 0; cnt_match = 0;
        send(1'b0, 4'd4);
        send(1'b1, 4'd3);
        idle(6);
        chk_int("b2b_len", cnt_valid, 7);
`ifdef FSM_RUNGEN_PREDICT_EN
        exp_m = 1;
`else
        exp_m = 0;
`endif
        chk_int("b2b_match", cnt_match, exp_m);

        // Zero length in IDLE, then at end of a run.
        cnt_valid = 0;
        cyc(1'b1, 1'b1, 1'b1, 4'd0, acc);
        idle(2);
        send(1'b1, 4'd2);
        send(1'b1, 4'd0);
        idle(3);
        chk_int("zero_len", cnt_valid, 2);

        // Max length (0,15).
        cnt_valid = 0; cnt_match = 0;
        send(1'b0, 4'd15);
        idle(18);
        chk_int("max_len", cnt_valid, 15);
`ifdef FSM_RUNGEN_PREDICT_EN
        exp_m = 12;
`else
        exp_m = 0;
`endif
        chk_int("max_match", cnt_match, exp_m);

        // Reset mid-run (1,10), reset low in run cycle 3 with a command offered.
        cnt_valid = 0;
        send(1'b1, 4'd10);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 4'd2, acc);
        idle(3);
        chk_int("abort_len", cnt_valid, 3);
        cnt_valid = 0;
        send(1'b0, 4'd2);
        idle(4);
        chk_int("after_abort_len", cnt_valid, 2);

        // Randomized traffic, including rare resets and extreme lengths.
        for (int i = 0; i < 600; i++) begin
            logic       r, v, b;
            logic [3:0] l;
            int         sel;
            r   = ($urandom_range(0, 39) != 0);
            v   = ($urandom_range(0, 2) != 0);
            b   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            sel = $urandom_range(0, 9);
            if (sel == 0)      l = 4'd0;
            else if (sel == 1) l = 4'd15;
            else               l = 4'($urandom_range(1, 6));
            cyc(r, v, b, l, acc);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_run_generator.md
# fsm_run_generator

Serial run-length pattern transmitter: accepts commands of the form "emit bit B for N consecutive cycles" over a valid/ready handshake and drives them out one bit per clock. It is the stimulus end of the continuous-input detector path; its `out` feeds the `in` of a run detector, and back-to-back commands are emitted with no idle gap. An optional predictor output flags every cycle in which four identical bits have just been driven.

## Interface

- `LEN_W`, default 4: width of `cmd_len`; run lengths 0..2^LEN_W-1.

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command this cycle.
- `cmd_bit` input 1: bit value to emit.
- `cmd_len` input LEN_W: number of cycles to emit `cmd_bit`.
- `out` output 1: serial bit; 0 when `out_valid` is 0.
- `out_valid` output 1: `out` carries a command bit this cycle.
- `busy` output 1: run in progress (equals `out_valid`).
- `match` output 1: predictor flag (see Configuration).

## Operation

- States: IDLE, RUN. Registers: `state`, `cur_bit`, `remain` (LEN_W bits, bits still to emit after the current one), plus the predictor history when enabled.
- Accept = `cmd_valid & cmd_ready` at a rising edge.
- `cmd_ready` = `reset` & (state==IDLE | (state==RUN & remain==0)); combinational from registers; forced 0 while `reset` is low.
- IDLE, accept with `cmd_len`≥1: next cycle state=RUN, `cur_bit`=`cmd_bit`, `remain`=`cmd_len`-1.
- IDLE, accept with `cmd_len`=0: command consumed, no emission, stay IDLE.
- RUN, `remain`>0: `remain` decrements each cycle; `cmd_ready`=0; `cmd_valid` ignored.
- RUN, `remain`=0, no accept: next cycle IDLE.
- RUN, `remain`=0, accept with `cmd_len`≥1: next cycle stays RUN with new `cur_bit`/`remain`; no gap cycle.
- RUN, `remain`=0, accept with `cmd_len`=0: command consumed, next cycle IDLE.
- Outputs registered-state decode: `out_valid`=`busy`=(state==RUN); `out`=`cur_bit` & `out_valid`.
- `cmd_len` arithmetic: unsigned, LEN_W bits; max length 2^LEN_W-1 (15 at default).

## Timing

- Reset (`reset`=0 at an edge): next cycle state=IDLE, `remain`=0, `cur_bit`=0, history cleared; `out`=0, `out_valid`=0, `busy`=0, `match`=0; `cmd_ready`=1 once `reset` is high.
- Reset mid-run aborts the run immediately; remaining bits are discarded; a command offered during reset is not accepted.
- Latency: first bit of an accepted command on `out` the cycle after the accept edge.
- A run of length N occupies exactly N consecutive `out_valid` cycles.
- Chained commands: last bit of run k and first bit of run k+1 are in adjacent cycles.
- Command inputs are sampled only at accept; later changes do not affect the active run.

## Configuration

- `FSM_RUNGEN_PREDICT_EN` defined: 3-bit history of previously emitted bits plus a 2-bit saturating count of consecutive `out_valid` cycles. `match`=1 in a cycle when `out_valid`=1, the count of preceding consecutive valid cycles is ≥3, and `out` equals all three history bits. History and count clear on any `out_valid`=0 cycle and on reset. `match` is combinational from registers and aligned with `out`. This matches a 4-in-a-row detector's output one cycle later.
- Not defined: history logic is absent; `match` is tied to 0; the port remains so the interface is unchanged.

## Test plan

- Reset: hold `reset`=0 for 2 cycles with `cmd_valid`=1 -> `out`=`out_valid`=`busy`=`match`=0, `cmd_ready`=0, no command accepted; release -> `cmd_ready`=1.
- Single run: accept (bit=1, len=5) -> `out`=1 for exactly 5 cycles starting the next cycle, `cmd_ready`=1 only in the 5th cycle, then IDLE; with macro, `match`=1 in cycles 4 and 5 only.
- Back-to-back: (0,4) then (1,3) offered continuously -> `out` = 0,0,0,0,1,1,1 with no gap; with macro, `match`=1 only on the 4th zero.
- Zero length: accept (1,0) in IDLE -> no `out_valid`, `cmd_ready` stays 1; (1,0) accepted at the end of a run -> IDLE the next cycle.
- Max length: accept (0,15) -> 15 valid zero cycles, `remain` does not wrap; with macro, `match`=1 for cycles 4..15.
- Reset mid-run: accept (1,10), pull `reset` low in cycle 3 -> all outputs 0 the next cycle and the run is not resumed; a new (0,2) after release emits exactly 2 zeros.
